// File: rtl/load_align_unit.sv
// load_align_unit
//   Sequential load alignment unit. It accepts one load request at a time,
//   issues word-aligned reads to the data memory port, and merges, shifts and
//   sign/zero-extends the bytes. It returns a tagged response to writeback.
//
//   Optional feature (macro MISALIGNED_SPLIT_EN):
//     defined   - a load that crosses a word boundary is split into two reads.
//     undefined - a crossing load faults immediately with no memory access.
//                 The REQ1/WAIT1 states and the first-word holding register
//                 are not built.
//
//   Ports:
//     clk, reset       core clock, synchronous active-high reset
//     req_*            load request from the LSU (valid/ready, addr, mode, tag)
//     mem_req_*        word-aligned read request to data memory (valid/ready)
//     mem_rvalid/rdata in-order read data, at most one access outstanding
//     rsp_*            response to writeback (valid/ready, data, fault, tag)
`timescale 1ns/1ps

package load_align_pkg;
  typedef enum logic [2:0] {
    MASK_BYTE   = 3'd0,
    MASK_BYTE_U = 3'd1,
    MASK_HALF   = 3'd2,
    MASK_HALF_U = 3'd3,
    MASK_WORD   = 3'd4
  } mask_mode_t;
endpackage

module load_align_unit
  import load_align_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  mask_mode_t        req_mask_mode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault,
  output logic [TAG_W-1:0]  rsp_tag
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
`ifdef MISALIGNED_SPLIT_EN
    REQ1,
    WAIT1,
`endif
    RESP
  } state_t;

  state_t           state_q;
  logic [1:0]       off_q;
  mask_mode_t       mode_q;
  logic [TAG_W-1:0] tag_q;
`ifdef MISALIGNED_SPLIT_EN
  logic             cross_q;
  logic [31:0]      w0_q;
`endif

  function automatic logic is_legal(input mask_mode_t m);
    return m inside {MASK_BYTE, MASK_BYTE_U, MASK_HALF, MASK_HALF_U, MASK_WORD};
  endfunction

  // words = {w1, w0}; the shift brings the addressed byte down to bit 0.
  function automatic logic [31:0] align_extend(input logic [63:0]  words,
                                               input logic [1:0]   off,
                                               input mask_mode_t   m);
    logic [31:0] merged;
    merged = 32'(words >> {off, 3'b000});
    case (m)
      MASK_BYTE:   return {{24{merged[7]}}, merged[7:0]};
      MASK_BYTE_U: return {24'h0, merged[7:0]};
      MASK_HALF:   return {{16{merged[15]}}, merged[15:0]};
      MASK_HALF_U: return {16'h0, merged[15:0]};
      MASK_WORD:   return merged;
      default:     return 32'h0;
    endcase
  endfunction

  // Request decode, evaluated on the live request in IDLE.
  logic [1:0] req_off;
  logic       req_legal;
  logic       req_cross;
  logic       req_reject;

  assign req_off   = req_addr[1:0];
  assign req_legal = is_legal(req_mask_mode);
  assign req_cross = (((req_mask_mode == MASK_HALF) || (req_mask_mode == MASK_HALF_U))
                      && (req_off == 2'd3))
                   || ((req_mask_mode == MASK_WORD) && (req_off != 2'd0));

`ifdef MISALIGNED_SPLIT_EN
  assign req_reject = !req_legal;
`else
  // Without splitting, a crossing load cannot be served and faults at once.
  assign req_reject = !req_legal || req_cross;
`endif

  assign req_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    if (reset) begin
      state_q       <= IDLE;
      off_q         <= 2'd0;
      mode_q        <= MASK_BYTE;
      tag_q         <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'h0;
      rsp_fault     <= 1'b0;
      rsp_tag       <= '0;
`ifdef MISALIGNED_SPLIT_EN
      cross_q       <= 1'b0;
      w0_q          <= 32'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q  <= req_off;
            mode_q <= req_mask_mode;
            tag_q  <= req_tag;
`ifdef MISALIGNED_SPLIT_EN
            cross_q <= req_cross;
`endif
            if (req_reject) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_data  <= 32'h0;
              rsp_tag   <= req_tag;
            end else begin
              state_q       <= REQ0;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end

        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= WAIT0;
          end
        end

        WAIT0: begin
          if (mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
            w0_q <= mem_rdata;
            if (cross_q) begin
              // Second word follows; address wraps modulo 2^ADDR_W.
              state_q       <= REQ1;
              mem_req_valid <= 1'b1;
              mem_addr      <= mem_addr + ADDR_W'(4);
            end else begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_data  <= align_extend({32'h0, mem_rdata}, off_q, mode_q);
              rsp_tag   <= tag_q;
            end
`else
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_data  <= align_extend({32'h0, mem_rdata}, off_q, mode_q);
            rsp_tag   <= tag_q;
`endif
          end
        end

`ifdef MISALIGNED_SPLIT_EN
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= WAIT1;
          end
        end

        WAIT1: begin
          if (mem_rvalid) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_data  <= align_extend({mem_rdata, w0_q}, off_q, mode_q);
            rsp_tag   <= tag_q;
          end
        end
`endif

        RESP: begin
          // Data and tag are left untouched so they stay readable after the
          // handshake; only valid drops.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
`timescale 1ns/1ps

module tb_load_align_unit;
  import load_align_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  mask_mode_t  req_mask_mode;
  logic [4:0]  req_tag;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic [4:0]  rsp_tag;

  load_align_unit #(.ADDR_W(32), .TAG_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_mask_mode (req_mask_mode),
    .req_tag       (req_tag),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_fault     (rsp_fault),
    .rsp_tag       (rsp_tag)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Two-word memory model.
  logic [31:0] wa_addr, wa_data, wb_addr, wb_data;
  logic        rvalid_en;
  logic        spurious_rvalid;
  logic [31:0] log_addr [0:63];
  int          req_count = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == wa_addr) return wa_data;
    else if (a == wb_addr) return wb_data;
    else return 32'hDEAD_BEEF;
  endfunction

  // Accepted read at edge N returns data during cycle N+1.
  always @(posedge clk) begin
    logic        hs;
    logic        en;
    logic [31:0] a;
    hs = mem_req_valid && mem_req_ready;
    en = rvalid_en;
    a  = mem_addr;
    #1;
    mem_rvalid = (hs && en) || spurious_rvalid;
    if (hs) begin
      mem_rdata = mem_word(a);
      log_addr[req_count % 64] = a;
      req_count++;
    end
  end

  task automatic do_load(input string name, input logic [31:0] addr, input mask_mode_t mode,
                         input logic [4:0] tag, input logic [31:0] exp_data, input logic exp_fault,
                         input int exp_nreq, input logic [31:0] exp_a0, input logic [31:0] exp_a1,
                         input int stall_mem, input int stall_rsp);
    int base;
    int lat;
    int exp_lat;
    base    = req_count;
    exp_lat = (exp_nreq == 0) ? 1 : (exp_nreq == 1) ? 3 + stall_mem : 5;
    mem_req_ready = (stall_mem == 0);
    @(negedge clk);
    check({name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; req_mask_mode = mode; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'h0;
    lat = 1;
    if (exp_nreq > 0) begin
      check({name, "_mreq_t1"}, 32'(mem_req_valid), 32'd1);
      check({name, "_maddr_t1"}, mem_addr, exp_a0);
    end else begin
      check({name, "_no_mreq"}, 32'(mem_req_valid), 32'd0);
    end
    for (int i = 0; i < stall_mem; i++) begin
      check({name, "_stall_mreq"}, 32'(mem_req_valid), 32'd1);
      check({name, "_stall_maddr"}, mem_addr, exp_a0);
      @(negedge clk);
      lat++;
    end
    mem_req_ready = 1'b1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i <= stall_rsp; i++) begin
      check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_data"}, rsp_data, exp_data);
      check({name, "_fault"}, 32'(rsp_fault), 32'(exp_fault));
      check({name, "_tag"}, 32'(rsp_tag), 32'(tag));
      check({name, "_busy"}, 32'(req_ready), 32'd0);
      if (i < stall_rsp) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({name, "_idle"}, 32'(req_ready), 32'd1);
    check({name, "_data_kept"}, rsp_data, exp_data);
    check({name, "_tag_kept"}, 32'(rsp_tag), 32'(tag));
    check({name, "_nreq"}, 32'(req_count - base), 32'(exp_nreq));
    if (exp_nreq >= 1) check({name, "_addr0"}, log_addr[base % 64], exp_a0);
    if (exp_nreq >= 2) check({name, "_addr1"}, log_addr[(base + 1) % 64], exp_a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_mask_mode = MASK_BYTE;
    req_tag = 5'h0; mem_req_ready = 1'b1; rsp_ready = 1'b0;
    rvalid_en = 1'b1; spurious_rvalid = 1'b0;
    wa_addr = 32'h100; wa_data = 32'h8899_AABB; wb_addr = 32'h104; wb_data = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mreq", 32'(mem_req_valid), 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);

    // Aligned word load.
    do_load("lw_100", 32'h100, MASK_WORD, 5'd1, 32'h8899_AABB, 1'b0, 1, 32'h100, 32'h0, 0, 0);

    // Byte/half extraction from one word.
    wa_data = 32'h8011_2233;
    do_load("lb_103", 32'h103, MASK_BYTE, 5'd2, 32'hFFFF_FF80, 1'b0, 1, 32'h100, 32'h0, 0, 0);
    do_load("lbu_103", 32'h103, MASK_BYTE_U, 5'd3, 32'h0000_0080, 1'b0, 1, 32'h100, 32'h0, 0, 0);
    do_load("lhu_102", 32'h102, MASK_HALF_U, 5'd4, 32'h0000_8011, 1'b0, 1, 32'h100, 32'h0, 0, 0);
    do_load("lh_102", 32'h102, MASK_HALF, 5'd5, 32'hFFFF_8011, 1'b0, 1, 32'h100, 32'h0, 0, 0);

    // Non-crossing misaligned half completes in one read.
    wa_data = 32'h44B3_2211;
    do_load("lh_101", 32'h101, MASK_HALF, 5'd6, 32'hFFFF_B322, 1'b0, 1, 32'h100, 32'h0, 0, 0);

    // Crossing word load.
    wa_data = 32'h4433_2211; wb_addr = 32'h104; wb_data = 32'h8877_6655;
`ifdef MISALIGNED_SPLIT_EN
    do_load("lw_101", 32'h101, MASK_WORD, 5'd7, 32'h5544_3322, 1'b0, 2, 32'h100, 32'h104, 0, 0);
`else
    do_load("lw_101", 32'h101, MASK_WORD, 5'd7, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
`endif

    // Crossing half load at the top of the address space.
    wa_addr = 32'hFFFF_FFFC; wa_data = 32'hAB00_0000; wb_addr = 32'h0; wb_data = 32'h0000_00CD;
`ifdef MISALIGNED_SPLIT_EN
    do_load("lh_wrap", 32'hFFFF_FFFF, MASK_HALF, 5'd8, 32'hFFFF_CDAB, 1'b0, 2,
            32'hFFFF_FFFC, 32'h0, 0, 0);
`else
    do_load("lh_wrap", 32'hFFFF_FFFF, MASK_HALF, 5'd8, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
`endif

    // Illegal mask mode faults with no memory access.
    do_load("illegal", 32'h100, mask_mode_t'(3'd6), 5'd9, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);

    // Backpressure on both sides.
    wa_addr = 32'h100; wa_data = 32'h8899_AABB;
    do_load("bp_lw", 32'h100, MASK_WORD, 5'h1F, 32'h8899_AABB, 1'b0, 1, 32'h100, 32'h0, 3, 4);

    // Reset during an in-flight access (second read when split is built).
    wa_data = 32'h4433_2211; wb_addr = 32'h104; wb_data = 32'h8877_6655;
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_tag = 5'd12; req_mask_mode = MASK_WORD;
`ifdef MISALIGNED_SPLIT_EN
    req_addr = 32'h101;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rvalid_en = 1'b0;
    @(negedge clk);
    check("rst_pre_maddr", mem_addr, 32'h104);
`else
    req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    rvalid_en = 1'b0;
    @(negedge clk);
    check("rst_pre_maddr", mem_addr, 32'h100);
`endif
    check("rst_pre_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rvalid_en = 1'b1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_mreq", 32'(mem_req_valid), 32'd0);
    check("mid_rst_maddr", mem_addr, 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    check("mid_rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);

    // Spurious read data while idle is ignored.
    spurious_rvalid = 1'b1;
    @(negedge clk);
    spurious_rvalid = 1'b0;
    @(negedge clk);
    check("spur_rsp_valid", 32'(rsp_valid), 32'd0);
    check("spur_req_ready", 32'(req_ready), 32'd1);
    check("spur_mreq", 32'(mem_req_valid), 32'd0);

    // Fresh load after reset.
    wa_addr = 32'h200; wa_data = 32'h1234_5678;
    do_load("lw_200", 32'h200, MASK_WORD, 5'd13, 32'h1234_5678, 1'b0, 1, 32'h200, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential successor to the combinational load extender.
- Accepts one load request at a time from the LSU and issues word-aligned reads to the data memory port.
- Misaligned loads that cross a word boundary are split into two word reads, then merged, shifted and sign/zero-extended.
- Returns a tagged, valid/ready response to writeback. Sits between the LSU address stage and the data memory interface.

Parameters:
- ADDR_W, 32, byte-address width of the request and memory ports.
- TAG_W, 5, width of the opaque request tag (destination register index) returned with the response.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- req_addr  in  ADDR_W  byte address.
- req_mask_mode  in  mask_mode_t  MASK_BYTE/BYTE_U/HALF/HALF_U/WORD.
- req_tag  in  TAG_W  tag, returned unchanged.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  word-aligned read address; low 2 bits always 0.
- mem_rvalid  in  1  read data valid. In order; one outstanding.
- mem_rdata  in  32  read data word.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  extended load result.
- rsp_fault  out  1  misaligned (macro off) or illegal mask_mode.
- rsp_tag  out  TAG_W  tag of the response.

Behaviour:
- Reset (synchronous, highest priority, effective any state):
  - state=IDLE.
  - mem_req_valid=0, mem_addr=0.
  - rsp_valid=0, rsp_data=0, rsp_fault=0, rsp_tag=0.
  - Captured words cleared.
  - An in-flight access is abandoned. The memory port shares this reset, so no stale mem_rvalid follows.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - On req_valid, latch addr, mask_mode and tag; off = addr[1:0].
  - Set cross = (HALF*, off==3) or (WORD, off!=0).
  - Illegal mask_mode -> RESP with fault=1, data=0, no memory access.
  - Otherwise -> REQ0.
- REQ0:
  - mem_req_valid=1, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Held stable until mem_req_ready; then -> WAIT0.
- WAIT0:
  - On mem_rvalid, capture w0.
  - If cross, -> REQ1; else -> RESP.
  - mem_rvalid is ignored in every state other than WAIT0/WAIT1.
- REQ1:
  - mem_addr = word address of REQ0 + 4, modulo 2^ADDR_W. So 0xFFFFFFFC wraps to 0x00000000.
  - Same handshake as REQ0; then -> WAIT1.
- WAIT1: on mem_rvalid, capture w1 and -> RESP.
- Merge and extend:
  - merged = ({w1,w0} >> 8*off)[31:0]; w1 is treated as 0 when cross=0.
  - BYTE/HALF are sign-extended from bit 7/15 of merged; BYTE_U/HALF_U are zero-extended; WORD passes merged through.
- RESP:
  - rsp_valid=1 with data, fault and tag registered; all stable while rsp_valid && !rsp_ready.
  - On rsp_ready -> IDLE. rsp_valid drops the next cycle; rsp_data/tag retain their values.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Latency, aligned load, request accepted in cycle T:
  - mem_req_valid in T+1.
  - With mem_req_ready=1 and mem_rvalid at T+2, rsp_valid at T+3.
  - Split loads add 2 cycles minimum.
- mem_req_valid is never asserted outside REQ0/REQ1. At most one memory request is outstanding.

Optional Feature:
- MISALIGNED_SPLIT_EN defined: behaviour as above; crossing loads are split into two reads.
- Not defined:
  - Crossing loads go IDLE -> RESP directly with rsp_fault=1, rsp_data=0 and no memory access.
  - REQ1/WAIT1 are not built.
  - Non-crossing misaligned loads (e.g. HALF at off 1) still complete normally.

Test Plan:
- LW addr 0x100, mem word 0x8899AABB, mem_req_ready=1, rvalid next cycle -> mem_addr 0x100, rsp_data 0x8899AABB, rsp_fault 0, rsp_valid 3 cycles after acceptance.
- LB addr 0x103, word 0x80112233 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- LW addr 0x101, words 0x44332211 @0x100 and 0x88776655 @0x104 (macro on) -> two requests 0x100 then 0x104, rsp_data 0x55443322. With the macro off -> no mem request, rsp_fault 1, data 0.
- LH addr 0xFFFFFFFF, word 0xAB000000 @0xFFFFFFFC, 0x000000CD @0x0 (macro on) -> second mem_addr 0x00000000, rsp_data 0xFFFFCDAB.
- Backpressure: mem_req_ready low 3 cycles, rsp_ready low 4 cycles -> mem_addr and rsp_* stable throughout; req_ready=0 until one cycle after rsp_ready.
- Reset asserted in WAIT1 -> next cycle all outputs 0 and req_ready=1. A fresh LW addr 0x200 completes correctly; a spurious mem_rvalid in IDLE is ignored.
